// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e     : arbiter FSM encoding (IDLE / ACCESS / RESP)
//   DEF_ADDR_W  : default data-memory address width
//   DEF_DATA_W  : default data-memory word width
package dm_arbiter_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/rr_select.sv
// Round-robin winner search (combinational).
//   req  : per-core request vector
//   last : index of the most recently served core
//   idx  : first requester found searching upward from last+1, wrapping
//   vld  : at least one request present
module rr_select #(
   parameter int NUM_CORES = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     last,
   output logic [IDX_W-1:0]     idx,
   output logic                 vld
);

   logic [IDX_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest requester after
   // 'last' is the final (winning) assignment. With one core every offset
   // maps to core 0.
   always_comb begin
      idx  = '0;
      vld  = 1'b0;
      cand = '0;
      for (int i = NUM_CORES; i >= 1; i--) begin
         cand = IDX_W'((int'(last) + i) % NUM_CORES);
         if (req[cand]) begin
            idx = cand;
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_CORES
// cores. Every transaction is IDLE -> ACCESS -> RESP: the winner's request
// is latched in IDLE, the memory strobe is high for the ACCESS cycle and a
// one-cycle ack with read data is returned in RESP. All outputs come from
// flops.
//   clk, rst_n                  : clock, async active-low reset
//   core_req/wr/addr/wdata      : per-core request ports (packed per core)
//   core_gnt, core_ack          : one-hot owner / completion pulse
//   core_rdata                  : read data, valid with core_ack
//   mem_en/wr/addr/wdata, mem_rdata : shared memory port
//   busy                        : FSM not in IDLE
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int IDX_W     = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CORES-1:0]          core_req,
   input  logic [NUM_CORES-1:0]          core_wr,
   input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
   input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
   output logic [NUM_CORES-1:0]          core_gnt,
   output logic [NUM_CORES-1:0]          core_ack,
   output logic [DATA_W-1:0]             core_rdata,
   output logic                          mem_en,
   output logic                          mem_wr,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic                          busy
);

   logic [NUM_CORES-1:0][ADDR_W-1:0] addr_v;
   logic [NUM_CORES-1:0][DATA_W-1:0] wdata_v;

   assign addr_v  = core_addr;
   assign wdata_v = core_wdata;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      last_q, last_d;
   logic [IDX_W-1:0]      w_q, w_d;
   logic [IDX_W-1:0]      sel_idx;
   logic                  sel_vld;

   logic [NUM_CORES-1:0]  gnt_d, ack_d;
   logic                  en_d, wr_d;
   logic [ADDR_W-1:0]     addr_d;
   logic [DATA_W-1:0]     wdata_d, rdata_d;

   rr_select #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_rr_select (
      .req  (core_req),
      .last (last_q),
      .idx  (sel_idx),
      .vld  (sel_vld)
   );

   // Next-state and next-output logic. Strobes (en/wr/ack) default low so
   // each is high for exactly the one state that sets it.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      w_d     = w_q;
      gnt_d   = core_gnt;
      ack_d   = '0;
      en_d    = 1'b0;
      wr_d    = 1'b0;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      rdata_d = core_rdata;
      case (state_q)
         ST_IDLE: begin
            if (sel_vld) begin
               state_d        = ST_ACCESS;
               w_d            = sel_idx;
               gnt_d          = '0;
               gnt_d[sel_idx] = 1'b1;
               en_d           = 1'b1;
               wr_d           = core_wr[sel_idx];
               addr_d         = addr_v[sel_idx];
               wdata_d        = wdata_v[sel_idx];
            end
         end
         ST_ACCESS: begin
            // Memory data is captured for writes too; cores ignore it then.
            state_d = ST_RESP;
            rdata_d = mem_rdata;
            ack_d   = core_gnt;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            last_d  = w_q;
            gnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         last_q     <= IDX_W'(NUM_CORES - 1);
         w_q        <= '0;
         core_gnt   <= '0;
         core_ack   <= '0;
         core_rdata <= '0;
         mem_en     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         w_q        <= w_d;
         core_gnt   <= gnt_d;
         core_ack   <= ack_d;
         core_rdata <= rdata_d;
         mem_en     <= en_d;
         mem_wr     <= wr_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed transactions, expected acks queued by the
// stimulus and popped by an independent monitor on the falling edge.
module tb_dm_arbiter;

   localparam int NC = 4;
   localparam int AW = 16;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NC-1:0]     core_req = '0;
   logic [NC-1:0]     core_wr = '0;
   logic [NC*AW-1:0]  core_addr = '0;
   logic [NC*DW-1:0]  core_wdata = '0;
   logic [NC-1:0]     core_gnt, core_ack;
   logic [DW-1:0]     core_rdata;
   logic              mem_en, mem_wr;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata, mem_rdata;
   logic              busy;

   always #5 clk = ~clk;

   dm_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .IDX_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .core_req   (core_req),
      .core_wr    (core_wr),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_gnt   (core_gnt),
      .core_ack   (core_ack),
      .core_rdata (core_rdata),
      .mem_en     (mem_en),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   // Memory model: read data follows the address, write lands on the edge
   // that ends the strobe cycle.
   logic [DW-1:0] mem [0:65535];
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_en && mem_wr) mem[mem_addr] <= mem_wdata;

   typedef struct {
      logic [NC-1:0] ack;
      logic          is_rd;
      logic [DW-1:0] rd;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int c, input logic rd, input logic [DW-1:0] d);
      exp_t e;
      e.ack    = '0;
      e.ack[c] = 1'b1;
      e.is_rd  = rd;
      e.rd     = d;
      sb.push_back(e);
   endtask

   // Monitor: grant sanity every cycle, ack/rdata against the queue.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt_onehot0", {31'b0, $onehot0(core_gnt)}, 32'd1);
         if (core_ack != '0) begin
            if (sb.size() == 0) chk("unexpected_ack", 32'(core_ack), 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("ack_vec", 32'(core_ack), 32'(e.ack));
               if (e.is_rd) chk("rdata", 32'(core_rdata), 32'(e.rd));
            end
         end
      end
   end

   task automatic set_core(input int c, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
      core_wr[c]             = wr;
      core_addr[c*AW +: AW]  = a;
      core_wdata[c*DW +: DW] = d;
      core_req[c]            = 1'b1;
   endtask

   // One isolated transaction from IDLE, with cycle-exact strobe checks.
   task automatic single(input int c, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                         input string tag);
      logic [NC-1:0] oh;
      oh    = '0;
      oh[c] = 1'b1;
      set_core(c, wr, a, d);
      push(c, !wr, exp_rd);
      @(negedge clk);
      chk({tag, "_en"},   32'(mem_en), 32'd1);
      chk({tag, "_wr"},   32'(mem_wr), 32'(wr));
      chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
      if (wr) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
      chk({tag, "_gnt"},  32'(core_gnt), 32'(oh));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({tag, "_en_off"}, 32'(mem_en), 32'd0);
      chk({tag, "_wr_off"}, 32'(mem_wr), 32'd0);
      chk({tag, "_ack"},    32'(core_ack), 32'(oh));
      core_req[c] = 1'b0;
      @(negedge clk);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   // Let several requesters run; optionally drop each one once acked.
   task automatic run_group(input logic drop_each, input int n_acks, input string tag);
      int got      = 0;
      int cyc      = 0;
      int last_cyc = -1;
      while (got < n_acks && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (core_ack != '0) begin
            got++;
            if (last_cyc >= 0) chk({tag, "_spacing"}, 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            if (got == n_acks) core_req = '0;
            else if (drop_each) core_req = core_req & ~core_ack;
         end
      end
      if (got < n_acks) chk({tag, "_timeout"}, 32'(got), 32'(n_acks));
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[16'h0010] = 8'hA5;
      for (int i = 0; i < NC; i++) mem[16'h0100 + i] = DW'(8'h30 + i);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_gnt",   32'(core_gnt), 32'd0);
      chk("rst_ack",   32'(core_ack), 32'd0);
      chk("rst_rdata", 32'(core_rdata), 32'd0);
      chk("rst_en",    32'(mem_en), 32'd0);
      chk("rst_wr",    32'(mem_wr), 32'd0);
      chk("rst_addr",  32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Contention: all four hold requests, order 0,1,2,3,0
      for (int i = 0; i < NC; i++) set_core(i, 1'b0, AW'(16'h0100 + i), '0);
      for (int i = 0; i < 5; i++) push(i % NC, 1'b1, DW'(8'h30 + (i % NC)));
      run_group(1'b0, 5, "cont");
      @(negedge clk);
      chk("cont_idle", 32'(busy), 32'd0);

      // Single read, write, read-back
      single(2, 1'b0, 16'h0010, 8'h00, 8'hA5, "rd2");
      single(1, 1'b1, 16'h1234, 8'h5C, 8'h00, "wr1");
      chk("mem_1234", 32'(mem[16'h1234]), 32'h5C);
      single(1, 1'b0, 16'h1234, 8'h00, 8'h5C, "rb1");

      // Fairness wrap: last=1, cores 0 and 3 together -> 3 then 0
      set_core(0, 1'b0, 16'h0100, '0);
      set_core(3, 1'b0, 16'h0103, '0);
      push(3, 1'b1, 8'h33);
      push(0, 1'b1, 8'h30);
      run_group(1'b1, 2, "wrap");
      @(negedge clk);

      // Reset during ACCESS: outputs clear without a clock edge, no ack
      set_core(1, 1'b1, 16'h0040, 8'h77);
      @(negedge clk);
      chk("mid_en_pre", 32'(mem_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_en",   32'(mem_en), 32'd0);
      chk("mid_wr",   32'(mem_wr), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_gnt",  32'(core_gnt), 32'd0);
      core_req = '0;
      repeat (2) begin
         @(negedge clk);
         chk("mid_noack", 32'(core_ack), 32'd0);
      end
      set_core(0, 1'b0, 16'h0100, '0);
      set_core(2, 1'b0, 16'h0102, '0);
      push(0, 1'b1, 8'h30);
      push(2, 1'b1, 8'h32);
      rst_n = 1'b1;
      run_group(1'b1, 2, "post");
      @(negedge clk);

      // Idle hold
      repeat (20) begin
         @(negedge clk);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_en",   32'(mem_en), 32'd0);
         chk("idle_ack",  32'(core_ack), 32'd0);
      end

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
